// File: rtl/lc_dco_pkg.sv
// lc_dco_pkg: shared constants, phase word type and helper functions for lc_dco
package lc_dco_pkg;
    localparam int DEF_ACC_W = 16;
    typedef logic [DEF_ACC_W-1:0] phase_t;
    function automatic int popcount(input logic [63:0] v);
        int n = 0;
        for (int i = 0; i < 64; i++) n += int'(v[i]);
        return n;
    endfunction
    function automatic bit params_ok(input int sw_w, input int acc_w, input int base, input int step);
        return (base - sw_w * step >= 1) && (longint'(base) <= (longint'(1) << (acc_w - 1)));
    endfunction
endpackage

// File: rtl/lc_dco_capbank.sv
// lc_dco_capbank: maps the capacitor switch word to a phase increment
module lc_dco_capbank import lc_dco_pkg::*; #(
    parameter int SW_Width = 8,
    parameter int ACC_W    = DEF_ACC_W,
    parameter int BASE_INC = 8192,
    parameter int STEP_INC = 512
) (
    input  logic [SW_Width-1:0] sw,
    output logic [ACC_W-1:0]    inc
);
    assign inc = ACC_W'(BASE_INC - popcount(64'(sw)) * STEP_INC);
endmodule

// File: rtl/lc_dco.sv
// lc_dco: phase-accumulator model of an LC DCO with differential square-wave output
module lc_dco import lc_dco_pkg::*; #(
    parameter int SW_Width = 8,
    parameter int ACC_W    = DEF_ACC_W,
    parameter int BASE_INC = 8192,
    parameter int STEP_INC = 512
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SW_Width-1:0] sw,
    output logic                outp,
    output logic                outn,
    output logic                Ibias
);
    if (!params_ok(SW_Width, ACC_W, BASE_INC, STEP_INC)) begin : g_bad_params
        $error("lc_dco: increment range must stay within 1..2^(ACC_W-1)");
    end
    logic [ACC_W-1:0] inc;
    logic [ACC_W-1:0] inc_q;
    logic [ACC_W-1:0] acc;
    lc_dco_capbank #(
        .SW_Width(SW_Width),
        .ACC_W   (ACC_W),
        .BASE_INC(BASE_INC),
        .STEP_INC(STEP_INC)
    ) u_capbank (
        .sw (sw),
        .inc(inc)
    );
    // acc is never cleared on sw changes so frequency steps stay phase-continuous
    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            inc_q <= ACC_W'(BASE_INC);
            Ibias <= 1'b0;
        end else begin
            acc   <= acc + inc_q;
            inc_q <= inc;
            Ibias <= 1'b1;
        end
    end
    assign outp = acc[ACC_W-1];
    assign outn = ~acc[ACC_W-1];
endmodule

// File: tb/tb_lc_dco.sv
// tb_lc_dco: directed self-checking bench for lc_dco
module tb_lc_dco;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] sw  = 8'd0;
    logic       outp, outn, ibias;
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    lc_dco dut (
        .clk  (clk),
        .rst  (rst),
        .sw   (sw),
        .outp (outp),
        .outn (outn),
        .Ibias(ibias)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_count(input int cycles, output int rises, output int highs);
        logic prev;
        prev  = outp;
        rises = 0;
        highs = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (outp && !prev) rises++;
            if (outp) highs++;
            prev = outp;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        sw  = 8'd0;
        repeat (3) tick();
        n_cmp++; if (outp !== 1'b0) begin n_bad++; $display("FAIL reset_outp got %b want 0", outp); end
        n_cmp++; if (outn !== 1'b1) begin n_bad++; $display("FAIL reset_outn got %b want 1", outn); end
        n_cmp++; if (ibias !== 1'b0) begin n_bad++; $display("FAIL reset_ibias got %b want 0", ibias); end
        n_cmp++; if (dut.acc !== 16'd0) begin n_bad++; $display("FAIL reset_acc got %0d want 0", dut.acc); end
        rst = 1'b0;
        tick();
        n_cmp++; if (ibias !== 1'b1) begin n_bad++; $display("FAIL release_ibias got %b want 1", ibias); end
        n_cmp++; if (dut.acc !== 16'd8192) begin n_bad++; $display("FAIL release_acc got %0d want 8192", dut.acc); end
    endtask

    task automatic test_period8;
        logic exp;
        for (int k = 1; k <= 16; k++) begin
            tick();
            exp = ((k % 8) >= 3) && ((k % 8) <= 6);
            n_cmp++; if (outp !== exp) begin n_bad++; $display("FAIL period8_outp k=%0d got %b want %b", k, outp, exp); end
            n_cmp++; if (outn !== ~exp) begin n_bad++; $display("FAIL period8_outn k=%0d got %b want %b", k, outn, ~exp); end
        end
    endtask

    task automatic test_sw_patterns;
        int r, h;
        sw = 8'd15;
        repeat (2) tick();
        run_count(32, r, h);
        n_cmp++; if (r !== 3) begin n_bad++; $display("FAIL sw15_rises got %0d want 3", r); end
        sw = 8'd127;
        repeat (2) tick();
        run_count(128, r, h);
        n_cmp++; if (r !== 9) begin n_bad++; $display("FAIL sw127_rises got %0d want 9", r); end
        sw = 8'd255;
        repeat (2) tick();
        run_count(64, r, h);
        n_cmp++; if (r !== 4) begin n_bad++; $display("FAIL sw255_rises got %0d want 4", r); end
        n_cmp++; if (h !== 32) begin n_bad++; $display("FAIL sw255_highs got %0d want 32", h); end
        for (int i = 0; i < 16; i++) begin
            tick();
            n_cmp++; if (outn !== ~outp) begin n_bad++; $display("FAIL sw255_diff got outp=%b outn=%b want complement", outp, outn); end
        end
    endtask

    task automatic test_step;
        logic [7:0]  codes [6] = '{8'd0, 8'd1, 8'd15, 8'd31, 8'd63, 8'd127};
        logic [15:0] incs  [6] = '{16'd8192, 16'd7680, 16'd6144, 16'd5632, 16'd5120, 16'd4608};
        logic [15:0] prev_inc, a0;
        int          r, h, prev_r, first_r;
        prev_inc = 16'd4096;
        prev_r   = 0;
        first_r  = 0;
        for (int i = 0; i < 6; i++) begin
            sw = codes[i];
            n_cmp++; if (dut.inc_q !== prev_inc) begin n_bad++; $display("FAIL step%0d_inc_hold got %0d want %0d", i, dut.inc_q, prev_inc); end
            tick();
            n_cmp++; if (dut.inc_q !== incs[i]) begin n_bad++; $display("FAIL step%0d_inc_load got %0d want %0d", i, dut.inc_q, incs[i]); end
            a0 = dut.acc;
            tick();
            n_cmp++; if (dut.acc !== 16'(a0 + incs[i])) begin n_bad++; $display("FAIL step%0d_acc got %0d want %0d", i, dut.acc, 16'(a0 + incs[i])); end
            run_count(98, r, h);
            if (i == 0) first_r = r;
            else begin
                n_cmp++; if (r > prev_r) begin n_bad++; $display("FAIL step%0d_monotonic got %0d rises want <= %0d", i, r, prev_r); end
            end
            prev_r   = r;
            prev_inc = incs[i];
        end
        n_cmp++; if (!(first_r > prev_r)) begin n_bad++; $display("FAIL step_span got first=%0d last=%0d want first > last", first_r, prev_r); end
    endtask

    task automatic test_reset_mid;
        bit found = 1'b0;
        int r, h;
        sw = 8'd0;
        repeat (2) tick();
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (outp) found = 1'b1;
        end
        n_cmp++; if (found !== 1'b1) begin n_bad++; $display("FAIL mid_wait_high got no outp=1 within 20 cycles want outp=1"); end
        rst = 1'b1;
        sw  = 8'd255;
        tick();
        n_cmp++; if (outp !== 1'b0) begin n_bad++; $display("FAIL mid_outp got %b want 0", outp); end
        n_cmp++; if (outn !== 1'b1) begin n_bad++; $display("FAIL mid_outn got %b want 1", outn); end
        n_cmp++; if (dut.acc !== 16'd0) begin n_bad++; $display("FAIL mid_acc got %0d want 0", dut.acc); end
        n_cmp++; if (ibias !== 1'b0) begin n_bad++; $display("FAIL mid_ibias got %b want 0", ibias); end
        n_cmp++; if (dut.inc_q !== 16'd8192) begin n_bad++; $display("FAIL mid_inc got %0d want 8192", dut.inc_q); end
        tick();
        rst = 1'b0;
        tick();
        n_cmp++; if (dut.acc !== 16'd8192) begin n_bad++; $display("FAIL resume_acc got %0d want 8192", dut.acc); end
        n_cmp++; if (dut.inc_q !== 16'd4096) begin n_bad++; $display("FAIL resume_inc got %0d want 4096", dut.inc_q); end
        n_cmp++; if (ibias !== 1'b1) begin n_bad++; $display("FAIL resume_ibias got %b want 1", ibias); end
        tick();
        n_cmp++; if (dut.acc !== 16'd12288) begin n_bad++; $display("FAIL resume_acc2 got %0d want 12288", dut.acc); end
        run_count(64, r, h);
        n_cmp++; if (r !== 4) begin n_bad++; $display("FAIL resume_rises got %0d want 4", r); end
    endtask

    initial begin
        test_reset();
        test_period8();
        test_sw_patterns();
        test_step();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
